// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift command sequencer.
package shift_seq_pkg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;
    localparam int REP_W = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } state_t;

endpackage

// File: rtl/rep_counter.sv
// Loadable down-counter that counts the shift cycles of one command.
module rep_counter #(
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [REP_W-1:0] value,
    input  logic             dec,
    output logic             last
);

    logic [REP_W-1:0] count_q;
    logic [REP_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == {{(REP_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_sequencer.sv
// Drives the multi-shifter through load / shift / capture for one command
// at a time and presents the captured word on a valid/ready result port.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = shift_seq_pkg::WIDTH,
    parameter int AMT_W = shift_seq_pkg::AMT_W,
    parameter int REP_W = shift_seq_pkg::REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_dir,
    input  logic [REP_W-1:0] cmd_reps,
    output logic [WIDTH-1:0] sh_d,
    output logic [AMT_W-1:0] sh_n,
    output logic             sh_r,
    output logic             sh_load,
    input  logic [WIDTH-1:0] sh_w,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             dir_q, dir_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             rep_last;

    // Counter is loaded during LOAD so it holds reps on the first SHIFT cycle.
    rep_counter #(
        .REP_W (REP_W)
    ) u_rep_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (state_q == LOAD),
        .value (reps_q),
        .dec   (state_q == SHIFT),
        .last  (rep_last)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        amt_d      = amt_q;
        dir_d      = dir_q;
        reps_d     = reps_q;
        res_data_d = res_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    data_d  = cmd_data;
                    amt_d   = cmd_amt;
                    dir_d   = cmd_dir;
                    reps_d  = cmd_reps;
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = (reps_q != '0) ? SHIFT : CAPTURE;
            SHIFT:   if (rep_last) state_d = CAPTURE;
            CAPTURE: begin
                res_data_d = sh_w;
                state_d    = RESULT;
            end
            RESULT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            amt_q      <= '0;
            dir_q      <= 1'b0;
            reps_q     <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            amt_q      <= amt_d;
            dir_q      <= dir_d;
            reps_q     <= reps_d;
            res_data_q <= res_data_d;
        end
    end

    // Shifter controls are zero outside LOAD/SHIFT so the shifter holds its word.
    always_comb begin
        sh_d    = '0;
        sh_n    = '0;
        sh_r    = 1'b0;
        sh_load = 1'b0;
        case (state_q)
            LOAD: begin
                sh_d    = data_q;
                sh_load = 1'b1;
            end
            SHIFT: begin
                sh_n = amt_q;
                sh_r = dir_q;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: behavioural shifter model plus a scoreboard of expected results.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int W = 8;
    localparam int A = 3;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_data;
    logic [A-1:0] cmd_amt;
    logic         cmd_dir;
    logic [R-1:0] cmd_reps;
    logic [W-1:0] sh_d;
    logic [A-1:0] sh_n;
    logic         sh_r;
    logic         sh_load;
    logic [W-1:0] sh_w;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         busy;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(W), .AMT_W(A), .REP_W(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .cmd_dir   (cmd_dir),
        .cmd_reps  (cmd_reps),
        .sh_d      (sh_d),
        .sh_n      (sh_n),
        .sh_r      (sh_r),
        .sh_load   (sh_load),
        .sh_w      (sh_w),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Downstream multi-shifter
    logic [W-1:0] w_q;
    always_ff @(posedge clk) begin
        if (sh_load)   w_q <= sh_d;
        else if (sh_r) w_q <= w_q >> sh_n;
        else           w_q <= w_q << sh_n;
    end
    assign sh_w = w_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           reps;
        int           acc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the LOAD cycle.
    task automatic send_cmd(input logic [W-1:0] d, input logic [A-1:0] a,
                            input logic dr, input logic [R-1:0] rp);
        exp_t e;
        int   i;
        cmd_data  = d;
        cmd_amt   = a;
        cmd_dir   = dr;
        cmd_reps  = rp;
        cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        e.data = d;
        for (int k = 0; k < int'(rp); k++) e.data = dr ? (e.data >> a) : (e.data << a);
        e.reps = int'(rp);
        e.acc  = cyc;
        sb.push_back(e);
        check("load_pulse", {31'd0, sh_load}, 32'd1);
        check("load_data", {24'd0, sh_d}, {24'd0, d});
        check("load_n", {29'd0, sh_n}, 32'd0);
        check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    endtask

    // Waits for res_valid, checks against the scoreboard, optionally stalls res_ready.
    task automatic wait_result(input int stall);
        exp_t         e;
        int           i;
        int           loads;
        logic [W-1:0] held;
        i = 0;
        loads = 0;
        while (!res_valid && i < 100) begin
            @(negedge clk);
            i++;
            if (sh_load) loads++;
        end
        if (!res_valid) begin
            check("res_timeout", 32'd0, 32'd1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check("res_data", {24'd0, res_data}, {24'd0, e.data});
        // Acceptance edge T is followed by cycle T+1; res_valid is due in cycle T+3+reps.
        check("latency", cyc - e.acc + 1, e.reps + 3);
        check("extra_load", loads, 0);
        $display("txn reps=%0d res_data=0x%02h expected=0x%02h cycles=%0d",
                 e.reps, res_data, e.data, cyc - e.acc + 1);
        held = res_data;
        for (int k = 0; k < stall; k++) begin
            res_ready = 1'b0;
            cmd_valid = (k == 1);
            cmd_data  = 8'h5A;
            cmd_reps  = 4'd1;
            @(negedge clk);
            check("stall_data", {24'd0, res_data}, {24'd0, held});
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("stall_sh_n", {29'd0, sh_n}, 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", {31'd0, res_valid}, 32'd0);
        check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_amt   = '0;
        cmd_dir   = DIR_LEFT;
        cmd_reps  = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {24'd0, res_data}, 32'd0);
        check("rst_sh_load", {31'd0, sh_load}, 32'd0);
        check("rst_sh_n", {29'd0, sh_n}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send_cmd(8'b01011100, 3'd1, DIR_LEFT, 4'd3);
        check("left_expect", {24'd0, sb[0].data}, 32'b11100000);
        wait_result(0);

        send_cmd(8'b01011100, 3'd2, DIR_RIGHT, 4'd2);
        check("right_expect", {24'd0, sb[0].data}, 32'b00000101);
        wait_result(0);

        send_cmd(8'hA5, 3'd3, DIR_LEFT, 4'd0);
        wait_result(0);

        send_cmd(8'h3C, 3'd1, DIR_RIGHT, 4'd2);
        wait_result(5);

        // Reset in the third shift cycle of a long command
        send_cmd(8'hFF, 3'd1, DIR_LEFT, 4'd8);
        repeat (3) @(negedge clk);
        check("mid_shift_n", {29'd0, sh_n}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_sh_n", {29'd0, sh_n}, 32'd0);
        check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_res_data", {24'd0, res_data}, 32'd0);
        send_cmd(8'h01, 3'd1, DIR_LEFT, 4'd1);
        wait_result(0);

        // Reset together with cmd_valid: command must be dropped
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 8'h77;
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rstcmd_busy", {31'd0, busy}, 32'd0);
        check("rstcmd_sh_load", {31'd0, sh_load}, 32'd0);

        // Reset while a result is pending
        send_cmd(8'hC3, 3'd0, DIR_LEFT, 4'd0);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        check("pending_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("lost_res_valid", {31'd0, res_valid}, 32'd0);
        check("lost_res_data", {24'd0, res_data}, 32'd0);

        send_cmd(8'hFF, 3'd7, DIR_LEFT, 4'd2);
        check("overshift_expect", {24'd0, sb[0].data}, 32'd0);
        wait_result(0);
        send_cmd(8'h80, 3'd0, DIR_LEFT, 4'd5);
        wait_result(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command sequencer that sits directly upstream of the multi-shifter and drives its d / n / r / load inputs.
- Accepts one shift command per handshake: data, shift amount, direction and repeat count.
- Loads the data into the shifter, clocks the requested number of shift cycles, then captures the shifter output.
- Presents the captured word on a valid/ready result port, so shift jobs run without hand-toggled load sequences.

Parameters:
- WIDTH, 8, data width (matches the shifter word).
- AMT_W, 3, shift-amount width.
- REP_W, 4, repeat-count width (0..15 shift cycles per command).

Ports:
- clk  in  1  rising-edge clock, shared with the shifter.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_data  in  WIDTH  word to load.
- cmd_amt  in  AMT_W  shift amount per cycle.
- cmd_dir  in  1  direction: 0 = left, 1 = right.
- cmd_reps  in  REP_W  number of shift cycles.
- sh_d  out  WIDTH  to shifter d.
- sh_n  out  AMT_W  to shifter n.
- sh_r  out  1  to shifter r.
- sh_load  out  1  to shifter load.
- sh_w  in  WIDTH  shifter output w.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Shifter contract (fixed):
  - On each clk rising edge: load=1 gives w<=d; otherwise w<=w shifted by n.
  - r=0 shifts left, r=1 shifts right; logical shift, zero fill.
  - n=0 holds w.
- Reset (rst=1 at an edge, from any state):
  - state=IDLE, cmd_ready=1, res_valid=0, res_data=0, busy=0.
  - sh_load=0, sh_n=0, sh_r=0, sh_d=0.
  - Command registers cleared; an in-flight command is discarded with no result.
- FSM: IDLE, LOAD, SHIFT, CAPTURE, RESULT. All outputs are decoded from registered state and registers only; none is combinational from inputs.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1: register data, amt, dir and reps, then go to LOAD.
- LOAD (1 cycle):
  - sh_load=1, sh_d=data, sh_n=0.
  - Next state is SHIFT if reps!=0, else CAPTURE.
- SHIFT:
  - sh_load=0, sh_n=amt, sh_r=dir.
  - The rep counter starts at reps and decrements each cycle.
  - Go to CAPTURE when the counter is 1 at the clock edge, giving exactly reps shift cycles.
- CAPTURE (1 cycle):
  - sh_n=0 so the shifter holds.
  - res_data<=sh_w at the end of the cycle; go to RESULT.
- RESULT:
  - res_valid=1; res_data and the shifter are held stable (sh_n=0, sh_load=0).
  - On res_ready=1: res_valid falls next cycle and the state goes to IDLE.
- Outside LOAD and SHIFT, sh_n=0 and sh_load=0, so the shifter never drifts while idle or stalled.
- Latency, with the command accepted at edge T:
  - LOAD occupies cycle T+1.
  - Shifts occupy T+2 .. T+1+reps.
  - CAPTURE is at T+2+reps.
  - res_valid is high from T+3+reps.
  - With res_ready held high, cmd_ready returns at T+4+reps.
- cmd_ready=0 in all states but IDLE; cmd_valid is ignored there, with no queuing.
- Boundaries:
  - reps=0: the result equals the loaded data.
  - amt=0 with any reps: the result equals the loaded data, after reps cycles.
  - Over-shift (amt*reps >= WIDTH): the result is 0.
  - rst asserted together with cmd_valid: reset wins and the command is dropped.
  - rst asserted while res_valid is high: the result is lost.

Decomposition:
- Package shift_seq_pkg holds:
  - state encoding: IDLE=0, LOAD=1, SHIFT=2, CAPTURE=3, RESULT=4, 3-bit;
  - default widths WIDTH/AMT_W/REP_W;
  - direction constants DIR_LEFT=0 and DIR_RIGHT=1.
- One sub-module, rep_counter:
  - REP_W-bit loadable down-counter;
  - ports clk, rst, load, value, dec, last;
  - last is high when count==1.

Test Plan:
- Left shift: data=8'b01011100, amt=1, dir=0, reps=3; res_data=8'b11100000, res_valid at T+6.
- Right shift: data=8'b01011100, amt=2, dir=1, reps=2; res_data=8'b00000101.
- Zero repeats: data=8'hA5, reps=0; res_data=8'hA5 at T+3; sh_load high for exactly 1 cycle.
- Backpressure: res_ready low for 5 cycles after res_valid. Required: res_data is stable, cmd_ready=0, a cmd_valid pulse is ignored, and sh_n stays 0. After res_ready=1, cmd_ready is 1 the next cycle.
- Reset mid-SHIFT: data=8'hFF, amt=1, reps=8, rst=1 in the 3rd shift cycle. Next cycle: IDLE, sh_n=0, res_valid=0, res_data=0, busy=0. A following command data=8'h01, amt=1, dir=0, reps=1 gives res_data=8'h02.
- Over-shift and back-to-back: data=8'hFF, amt=7, dir=0, reps=2 gives 8'h00. It is followed immediately by data=8'h80, amt=0, reps=5, giving 8'h80 with res_valid 8 cycles after acceptance.
